// File: rtl/load_sequencer_if.sv
// ---------------------------------------------------------------------------
// load_sequencer_if
//
// Purpose: bundles the command, source-beat, datapath-control and result
// handshake signals of the systolic MAC input sequencer.
//
// Signals:
//   start        command  -> sequencer  begin one load/compute job
//   src_valid    source   -> sequencer  beat valid
//   dest_ready   sequencer -> source    beat accept
//   next_row     sequencer -> datapath  row counter advance pulse
//   next_col     sequencer -> datapath  column counter advance pulse
//   load_in_done datapath -> sequencer  row/column registers filled
//   mac_clear    sequencer -> PE array  accumulator clear pulse
//   shift_en     sequencer -> PE array  systolic shift / MAC enable
//   res_valid    sequencer -> consumer  results stable and valid
//   res_ready    consumer -> sequencer  results taken
//   busy         sequencer -> command   job in progress
//   done         sequencer -> command   job completed pulse
//
// Modports:
//   master : the sequencer side (drives the control outputs)
//   slave  : the surrounding environment (command, source, datapath, consumer)
// ---------------------------------------------------------------------------
interface load_sequencer_if;
  logic start;
  logic src_valid;
  logic dest_ready;
  logic next_row;
  logic next_col;
  logic load_in_done;
  logic mac_clear;
  logic shift_en;
  logic res_valid;
  logic res_ready;
  logic busy;
  logic done;

  modport master (
    input  start,
    input  src_valid,
    input  load_in_done,
    input  res_ready,
    output dest_ready,
    output next_row,
    output next_col,
    output mac_clear,
    output shift_en,
    output res_valid,
    output busy,
    output done
  );

  modport slave (
    output start,
    output src_valid,
    output load_in_done,
    output res_ready,
    input  dest_ready,
    input  next_row,
    input  next_col,
    input  mac_clear,
    input  shift_en,
    input  res_valid,
    input  busy,
    input  done
  );
endinterface

// File: rtl/load_sequencer.sv
// ---------------------------------------------------------------------------
// load_sequencer
//
// Purpose: control FSM for the systolic MAC input datapath. Accepts N
// 64-bit operand beats (row word [63:32], column word [31:0]) from the
// source, pulses the datapath row/column counters once per accepted beat,
// waits for the datapath to report the operand registers full, runs the
// systolic array for COMPUTE_CYCLES shift cycles and then holds the result
// handshake until the consumer takes it.
//
// Parameters:
//   N              matrix dimension = number of load beats (default 4)
//   COMPUTE_CYCLES shift-enable cycles to drain the skewed lanes (default 10)
//   TIMEOUT        maximum WAIT_LD cycles when LOAD_TIMEOUT_EN is defined
//
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-low reset
//   bus    load_sequencer_if.master (command/source/datapath/result signals)
//   err    sticky load-timeout flag (only when LOAD_TIMEOUT_EN is defined)
//
// Build option:
//   LOAD_TIMEOUT_EN  when defined, WAIT_LD gives up after TIMEOUT cycles
//                    without load_in_done, sets err and returns to IDLE.
//                    When undefined, WAIT_LD waits indefinitely and there is
//                    no err port and no timeout counter.
// ---------------------------------------------------------------------------
module load_sequencer #(
  parameter int N              = 4,
  parameter int COMPUTE_CYCLES = 10,
  parameter int TIMEOUT        = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  load_sequencer_if.master        bus
`ifdef LOAD_TIMEOUT_EN
  ,
  output logic                    err
`endif
);

  localparam int BEAT_W = $clog2(N + 1);
  localparam int CMP_W  = $clog2(COMPUTE_CYCLES + 1);

  // Value of the beat counter just before the acceptance that completes
  // the operand set.
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(N - 1);
  // The compute counter is loaded on entry and COMPUTE runs until it has
  // counted down through zero, giving exactly COMPUTE_CYCLES shift cycles.
  localparam logic [CMP_W-1:0]  CMP_LOAD  = CMP_W'(COMPUTE_CYCLES - 1);

  localparam bit PARAMS_OK = (N >= 1) && (COMPUTE_CYCLES >= 1) && (TIMEOUT >= 1);

  generate
    if (!PARAMS_OK) begin : g_bad_params
      $error("load_sequencer: N, COMPUTE_CYCLES and TIMEOUT must all be >= 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_WAIT_LD = 3'd2,
    S_COMPUTE = 3'd3,
    S_RESULT  = 3'd4
  } state_t;

  state_t             state_reg;
  logic [BEAT_W-1:0]  beat_cnt_reg;
  logic [CMP_W-1:0]   cmp_cnt_reg;

  logic               dest_ready_reg;
  logic               next_row_reg;
  logic               next_col_reg;
  logic               mac_clear_reg;
  logic               shift_en_reg;
  logic               res_valid_reg;
  logic               busy_reg;

`ifdef LOAD_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  logic [TMO_W-1:0]   tmo_cnt_reg;
  logic               err_reg;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= S_IDLE;
      beat_cnt_reg   <= '0;
      cmp_cnt_reg    <= '0;
      dest_ready_reg <= 1'b0;
      next_row_reg   <= 1'b0;
      next_col_reg   <= 1'b0;
      mac_clear_reg  <= 1'b0;
      shift_en_reg   <= 1'b0;
      res_valid_reg  <= 1'b0;
      busy_reg       <= 1'b0;
`ifdef LOAD_TIMEOUT_EN
      tmo_cnt_reg    <= '0;
      err_reg        <= 1'b0;
`endif
    end else begin
      // Single-cycle strobes default low; only the branches below raise them.
      next_row_reg  <= 1'b0;
      next_col_reg  <= 1'b0;
      mac_clear_reg <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          if (bus.start) begin
            state_reg      <= S_LOAD;
            beat_cnt_reg   <= '0;
            dest_ready_reg <= 1'b1;
            busy_reg       <= 1'b1;
          end
        end

        S_LOAD: begin
          // load_in_done is deliberately not looked at here: an early
          // report from the datapath before all beats are in is ignored.
          if (bus.src_valid && dest_ready_reg) begin
            beat_cnt_reg <= beat_cnt_reg + BEAT_W'(1);
            next_row_reg <= 1'b1;
            next_col_reg <= 1'b1;
            if (beat_cnt_reg == BEAT_LAST) begin
              state_reg      <= S_WAIT_LD;
              dest_ready_reg <= 1'b0;
`ifdef LOAD_TIMEOUT_EN
              tmo_cnt_reg    <= '0;
`endif
            end
          end
        end

        S_WAIT_LD: begin
          if (bus.load_in_done) begin
            state_reg     <= S_COMPUTE;
            mac_clear_reg <= 1'b1;
            shift_en_reg  <= 1'b1;
            cmp_cnt_reg   <= CMP_LOAD;
          end
`ifdef LOAD_TIMEOUT_EN
          else if (tmo_cnt_reg == TMO_LAST) begin
            // Abandon the job: no done pulse, err stays set until reset.
            state_reg <= S_IDLE;
            busy_reg  <= 1'b0;
            err_reg   <= 1'b1;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
          end
`endif
        end

        S_COMPUTE: begin
          if (cmp_cnt_reg == '0) begin
            state_reg     <= S_RESULT;
            shift_en_reg  <= 1'b0;
            res_valid_reg <= 1'b1;
          end else begin
            cmp_cnt_reg <= cmp_cnt_reg - CMP_W'(1);
          end
        end

        S_RESULT: begin
          if (bus.res_ready) begin
            state_reg     <= S_IDLE;
            res_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
          end
        end

        default: begin
          state_reg      <= S_IDLE;
          dest_ready_reg <= 1'b0;
          shift_en_reg   <= 1'b0;
          res_valid_reg  <= 1'b0;
          busy_reg       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dest_ready = dest_ready_reg;
  assign bus.next_row   = next_row_reg;
  assign bus.next_col   = next_col_reg;
  assign bus.mac_clear  = mac_clear_reg;
  assign bus.shift_en   = shift_en_reg;
  assign bus.res_valid  = res_valid_reg;
  assign bus.busy       = busy_reg;
  // done must coincide with the res_ready that completes the handshake, so
  // it is decoded from the registered res_valid and the live res_ready.
  assign bus.done       = res_valid_reg && bus.res_ready;

`ifdef LOAD_TIMEOUT_EN
  assign err = err_reg;
`endif

endmodule

// File: doc/load_sequencer.md
# load_sequencer

Control FSM for the systolic MAC input datapath.
- Loads one 4x4 operand set by accepting four 64-bit beats from the source: row word in [63:32], column word in [31:0].
- Advances the datapath's row and column counters.
- Runs the systolic array for a fixed skewed-streaming window, then holds a result handshake.
- Sits between the top-level command interface and the input datapath / PE array.

## Interface
Parameters:
- N, default 4: matrix dimension, which is also the number of load beats.
- COMPUTE_CYCLES, default 10 (3*N-2): shift-enable cycles needed to drain the skewed 56-bit lanes.
- TIMEOUT, default 8: maximum cycles to wait for load_in_done.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  begin one load/compute job; sampled only in IDLE.
- src_valid  in  1  source beat valid.
- dest_ready  out  1  beat accept; a beat is accepted on an edge where src_valid && dest_ready.
- next_row  out  1  one-cycle pulse advancing the datapath row counter.
- next_col  out  1  one-cycle pulse advancing the datapath column counter.
- load_in_done  in  1  datapath pulse: all row and column registers filled.
- mac_clear  out  1  one-cycle accumulator clear at the start of compute.
- shift_en  out  1  systolic shift/MAC enable.
- res_valid  out  1  results stable and valid.
- res_ready  in  1  consumer has taken the results.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a job completes.
- err  out  1  sticky load-timeout flag; exists only with LOAD_TIMEOUT_EN.

## Operation
States: IDLE, LOAD, WAIT_LD, COMPUTE, RESULT.

- **IDLE**
  - All outputs low.
  - start=1 moves to LOAD and clears the beat count to 0.
- **LOAD**
  - dest_ready=1, decoded as a Moore output.
  - On each accepted beat, the beat count increments.
  - next_row and next_col pulse together, registered, in the cycle after the acceptance.
  - The acceptance that brings the count to N moves to WAIT_LD.
  - src_valid low stalls with no pulses and no count change.
- **WAIT_LD**
  - dest_ready=0.
  - load_in_done=1 moves to COMPUTE.
  - load_in_done seen in LOAD before N beats have been accepted is ignored.
- **COMPUTE**
  - mac_clear=1 in the first cycle only.
  - shift_en=1 for exactly COMPUTE_CYCLES cycles, counted by a down-counter loaded on entry.
  - When the counter expires, move to RESULT.
- **RESULT**
  - res_valid=1 and held until res_ready=1.
  - When res_ready=1, move to IDLE with done=1 in that cycle.
- start outside IDLE is ignored; there is no queueing.
- Counter widths are $clog2(N+1) for beats and $clog2(COMPUTE_CYCLES+1) for compute. Counters never wrap within a job.

## Timing
- **Reset:** reset=0 on an edge forces IDLE on the next cycle, with every output and counter at 0, err included. This applies in any state, including mid-LOAD or mid-COMPUTE. No next_row/next_col pulse may follow a reset edge.
- **start:** start at edge t gives busy=1 and dest_ready=1 from t+1.
- **Beats:** a beat accepted at edge t gives next_row=next_col=1 during t+1 only.
  - Back-to-back beats give a pulse every cycle.
- **End of load:** after the N-th acceptance at edge t, dest_ready=0 from t+1. The final next_row/next_col pulse still occurs at t+1.
- **Compute entry:** load_in_done at edge t gives mac_clear=1 and shift_en=1 at t+1. shift_en is last high at t+COMPUTE_CYCLES.
- **Result:** res_valid rises at t+COMPUTE_CYCLES+1.
  - res_ready already high at that point gives a res_valid high for one cycle, done in the same cycle, then IDLE.
- **Latency** from start to res_valid, with continuous src_valid: N + 1 + (load_in_done delay) + COMPUTE_CYCLES + 1 cycles.

## Configuration
- **LOAD_TIMEOUT_EN** defined:
  - WAIT_LD counts cycles.
  - If load_in_done is absent for TIMEOUT cycles, err is set (sticky until reset) and the FSM returns to IDLE without done.
  - Port err exists.
- **LOAD_TIMEOUT_EN** undefined:
  - WAIT_LD waits indefinitely.
  - There is no err port and no timeout counter.

## Test plan
- **Nominal job:** reset low 2 cycles, then start; src_valid held high; load_in_done 1 cycle after the 4th pulse; res_ready held high.
  - Exactly 4 next_row/next_col pulses on consecutive cycles.
  - mac_clear for 1 cycle.
  - shift_en for exactly 10 cycles.
  - One done pulse, then busy=0.
- **Stalled source:** src_valid toggling 1,0,0,1,1,0,1 in LOAD.
  - Pulses only on the cycle after each acceptance, 4 total.
  - dest_ready drops after the 4th acceptance.
- **Backpressured result:** res_ready low for 5 cycles after res_valid rises.
  - res_valid stays high 6 cycles.
  - done coincides with res_ready=1.
- **Reset mid-operation:** reset=0 during the 2nd beat and, in a separate run, during the 6th compute cycle.
  - Next cycle IDLE with all outputs 0.
  - No stray pulses.
  - A new start runs a full 4-beat job.
- **Ignored inputs:** start pulsed during COMPUTE, and load_in_done pulsed during LOAD after 2 beats.
  - No effect.
  - The job completes normally.
- **Timeout (LOAD_TIMEOUT_EN):** load_in_done never asserted.
  - err=1 after 8 WAIT_LD cycles, then IDLE with no done.
  - err stays 1 until reset.
